// File: rtl/instruction_fetch.sv
// instruction_fetch: LEGv8 fetch stage. Owns the PC, holds the fetch address
// stable for READ_WAIT edges while the asynchronous instruction memory
// settles, then registers the instruction with its PC and offers it to decode
// over a valid/ready handshake. Taken-branch redirects reload the PC; a
// misaligned target parks the stage in a sticky FAULT state until Reset.
//
// RESET_PC must be 4-byte aligned and READ_WAIT must lie in 1..15 (it is
// loaded into a 4-bit down-counter).
module instruction_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned READ_WAIT = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Enable,
  output logic [63:0] Address,
  input  logic [31:0] InstrData,
  output logic [31:0] Instruction,
  output logic [63:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [63:0] RedirectTarget,
  output logic        Fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(READ_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic        target_aligned;

  assign target_aligned = (RedirectTarget[1:0] == 2'b00);

  // Next-state and datapath decisions: redirect beats the normal fetch flow,
  // and FAULT ignores everything (Reset is applied in the register block).
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // branches below leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;

    if (state_q == S_FAULT) begin
      valid_d = 1'b0;
    end else if (Redirect) begin
      // Any held instruction is flushed, including one being accepted now.
      valid_d = 1'b0;
      if (target_aligned) begin
        pc_d    = RedirectTarget;
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end else begin
        fault_d = 1'b1;
        state_d = S_FAULT;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Enable) begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          // Enable is not consulted here: a started fetch always completes.
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            instr_d    = InstrData;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 64'd4;  // wraps modulo 2^64
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (InstrReady) begin
            valid_d = 1'b0;
            if (Enable) begin
              cnt_d   = CNT_LOAD;
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous, active-high reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 64'd0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign Address     = pc_q;
  assign Instruction = instr_q;
  assign InstrPC     = instr_pc_q;
  assign InstrValid  = valid_q;
  assign Fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed vector table, a wrap-around
// sequence on a second instance, then randomized traffic against a
// timeline-based reference model.
module tb_instruction_fetch;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int          RW      = 2;
  localparam logic [31:0] I0      = 32'hF840_03E9;
  localparam logic [31:0] I1      = 32'hF840_83EA;
  localparam logic [31:0] I2      = 32'h9100_07E1;

  logic        clk = 1'b0;
  logic        rst, en, rdy, redir;
  logic [63:0] tgt;

  logic [63:0] addr, ipc, addr_w, ipc_w;
  logic [31:0] idata, instr, idata_w, instr_w;
  logic        valid, fault, valid_w, fault_w;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: three fixed words, everything else derived
  // from the address so different fetches return different data.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return I0;
      64'h4:   return I1;
      64'h40:  return I2;
      default: return a[31:0] ^ 32'hD503_201F;
    endcase
  endfunction

  assign idata   = mem_word(addr);
  assign idata_w = mem_word(addr_w);

  instruction_fetch dut (
    .CLK(clk), .Reset(rst), .Enable(en), .Address(addr), .InstrData(idata),
    .Instruction(instr), .InstrPC(ipc), .InstrValid(valid), .InstrReady(rdy),
    .Redirect(redir), .RedirectTarget(tgt), .Fault(fault)
  );

  instruction_fetch #(.RESET_PC(WRAP_PC), .READ_WAIT(RW)) dut_wrap (
    .CLK(clk), .Reset(rst), .Enable(en), .Address(addr_w), .InstrData(idata_w),
    .Instruction(instr_w), .InstrPC(ipc_w), .InstrValid(valid_w), .InstrReady(rdy),
    .Redirect(redir), .RedirectTarget(tgt), .Fault(fault_w)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic e, input logic y, input logic d,
                       input logic [63:0] t);
    rst = r; en = e; rdy = y; redir = d; tgt = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic        rst, en, rdy, redir;
    logic [63:0] tgt;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_ipc;
    logic [63:0] e_addr;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a fetch started at edge N captures at edge N+RW.
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr;
  logic        m_valid, m_fault, m_fetching;
  int          m_edge, m_cap_at;

  task automatic model_edge(input logic r, input logic e, input logic y, input logic d,
                            input logic [63:0] t);
    m_edge++;
    if (r) begin
      m_pc = 64'h0; m_valid = 1'b0; m_instr = 32'h0; m_ipc = 64'h0;
      m_fault = 1'b0; m_fetching = 1'b0;
    end else if (m_fault) begin
      m_valid = 1'b0;
    end else if (d) begin
      m_valid = 1'b0;
      if (t[1:0] == 2'b00) begin
        m_pc = t; m_fetching = 1'b1; m_cap_at = m_edge + RW;
      end else begin
        m_fault = 1'b1; m_fetching = 1'b0;
      end
    end else if (m_valid) begin
      if (y) begin
        m_valid = 1'b0;
        if (e) begin m_fetching = 1'b1; m_cap_at = m_edge + RW; end
      end
    end else if (m_fetching) begin
      if (m_edge == m_cap_at) begin
        m_instr = mem_word(m_pc); m_ipc = m_pc; m_valid = 1'b1;
        m_pc = m_pc + 64'd4; m_fetching = 1'b0;
      end
    end else if (e) begin
      m_fetching = 1'b1; m_cap_at = m_edge + RW;
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);

    //            rst   en    rdy   redir tgt     valid instr  ipc     addr    fault
    // Plain fetch with ready tied high.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b1, I0,    64'h0,  64'h4,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, I0,    64'h0,  64'h4,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, I0,    64'h0,  64'h4,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b1, I1,    64'h4,  64'h8,  1'b0});
    // Backpressure: five stalled edges after the first capture.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b1, I0,    64'h0,  64'h4,  1'b0});
    for (int k = 0; k < 5; k++)
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, I0, 64'h0, 64'h4, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, I0,    64'h0,  64'h4,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b0, I0,    64'h0,  64'h4,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b1, I1,    64'h4,  64'h8,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b1, I1,    64'h4,  64'h8,  1'b0});
    // Redirect to 0x40 out of HOLD flushes the held instruction.
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 64'h40, 1'b0, I1,    64'h4,  64'h40, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b0, I1,    64'h4,  64'h40, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b1, I2,    64'h40, 64'h44, 1'b0});
    // Misaligned redirect: sticky fault, later redirect ignored, reset clears.
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 64'h42, 1'b0, I2,    64'h40, 64'h44, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 64'h0,  1'b0, I2,    64'h40, 64'h44, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, I2,    64'h40, 64'h44, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    // Fetch up to PC=8, then reset one edge into that WAIT.
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b1, I0,    64'h0,  64'h4,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, I0,    64'h0,  64'h4,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, I0,    64'h0,  64'h4,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b1, I1,    64'h4,  64'h8,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, I1,    64'h4,  64'h8,  1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  64'h0,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  1'b1, I0,    64'h0,  64'h4,  1'b0});
    // Redirect coincident with valid&ready and Enable low still fetches.
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 64'h40, 1'b0, I0,    64'h0,  64'h40, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0, I0,    64'h0,  64'h40, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, I2,    64'h40, 64'h44, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, I2,    64'h40, 64'h44, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, I2,    64'h40, 64'h44, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, I2,    64'h40, 64'h44, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].rdy, vecs[i].redir, vecs[i].tgt);
      tick();
      check($sformatf("vec%0d_addr", i),  addr,  vecs[i].e_addr);
      check($sformatf("vec%0d_valid", i), valid, vecs[i].e_valid);
      check($sformatf("vec%0d_instr", i), instr, vecs[i].e_instr);
      check($sformatf("vec%0d_ipc", i),   ipc,   vecs[i].e_ipc);
      check($sformatf("vec%0d_fault", i), fault, vecs[i].e_fault);
    end

    // PC wrap-around on the instance reset to the top word of the space.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    check("wrap_reset_addr", addr_w, WRAP_PC);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    check("wrap_pre_valid", valid_w, 1'b0);
    tick();
    check("wrap_valid", valid_w, 1'b1);
    check("wrap_ipc",   ipc_w,   WRAP_PC);
    check("wrap_addr",  addr_w,  64'h0);
    check("wrap_instr", instr_w, mem_word(WRAP_PC));

    // Randomized traffic against the reference model.
    m_edge = 0; m_cap_at = 0;
    m_pc = 64'h0; m_ipc = 64'h0; m_instr = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0; m_fetching = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      logic        r_rst, r_en, r_rdy, r_redir;
      logic [63:0] r_tgt;
      r_rst   = (c == 0) || ($urandom_range(0, 99) < 3);
      r_en    = ($urandom_range(0, 9) < 7);
      r_rdy   = ($urandom_range(0, 1) == 1);
      r_redir = ($urandom_range(0, 99) < 6);
      r_tgt   = {52'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 5) == 0) r_tgt[1:0] = 2'($urandom_range(1, 3));
      model_edge(r_rst, r_en, r_rdy, r_redir, r_tgt);
      drive(r_rst, r_en, r_rdy, r_redir, r_tgt);
      tick();
      check($sformatf("rnd%0d_addr", c),  addr,  m_pc);
      check($sformatf("rnd%0d_valid", c), valid, m_valid);
      check($sformatf("rnd%0d_instr", c), instr, m_instr);
      check($sformatf("rnd%0d_ipc", c),   ipc,   m_ipc);
      check($sformatf("rnd%0d_fault", c), fault, m_fault);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
